// File: rtl/aes_pkg.sv
// Shared AES types and byte-index helpers for the round datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package aes_pkg;

    localparam int AES_STATE_BYTES = 16;

    typedef logic [7:0] aes_byte_t;

    // Packed element [15-k] holds byte k, so the 128-bit bus maps straight on:
    // byte k = state[127-8k -: 8].
    typedef logic [AES_STATE_BYTES-1:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_fsm_t;

    // Packed element position of FIPS-197 byte k (row = k%4, col = k/4).
    function automatic logic [3:0] byte_pos(input logic [3:0] k);
        return 4'd15 - k;
    endfunction

    // ShiftRows source: output byte (r,c) takes input byte (r,(c+r)%4).
    function automatic logic [3:0] shift_rows_src(input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        r = k[1:0];
        c = k[3:2];
        return {2'(c + r), r};
    endfunction

endpackage

// File: rtl/S_box.sv
// AES forward S-box, one byte in, one byte out.
// Latency: purely combinational.
// Backpressure: not applicable.
module S_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX_TAB [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_TAB[in_byte];

endmodule

// File: rtl/sub_bytes_stage.sv
// AES SubBytes stage, BYTES_PER_CYCLE S-box lookups per cycle, optional ShiftRows (SUB_BYTES_SHIFT_ROWS_EN).
// Latency: 16/BYTES_PER_CYCLE+1 cycles from accept to out_valid.
// Backpressure: result held in DONE until out_ready; a new state is accepted in the same cycle it drains.
module sub_bytes_stage
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam int         NUM_STEPS  = AES_STATE_BYTES / BYTES_PER_CYCLE;
    localparam int         STEP_SHIFT = $clog2(BYTES_PER_CYCLE);
    localparam logic [3:0] LAST_IDX   = 4'(NUM_STEPS - 1);

    sb_fsm_t    fsm_q, fsm_d;
    logic [3:0] idx_q, idx_d;
    aes_state_t st_q, st_d;
    aes_state_t result;
    logic [3:0] base;
    aes_byte_t  sb_in  [BYTES_PER_CYCLE];
    aes_byte_t  sb_out [BYTES_PER_CYCLE];

    // First byte handled this step; bytes advance in FIPS order from byte 0.
    assign base = 4'(idx_q << STEP_SHIFT);

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        assign sb_in[g] = st_q[byte_pos(base + 4'(g))];
        S_box u_sbox (
            .in_byte  (sb_in[g]),
            .out_byte (sb_out[g])
        );
    end

    // State, counter and working register update; reset drops any in-flight state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            idx_q <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
            st_q  <= st_d;
        end
    end

    // Next-state, handshake and in-place substitution of the selected bytes.
    always_comb begin
        fsm_d     = fsm_q;
        idx_d     = idx_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d  = in_state;
                    fsm_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    st_d[byte_pos(base + 4'(j))] = sb_out[j];
                end
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    fsm_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        st_d  = in_state;
                        fsm_d = BUSY;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Output byte arrangement; ShiftRows is pure wiring on the finished state.
    always_comb begin
        result = st_q;
`ifdef SUB_BYTES_SHIFT_ROWS_EN
        for (int k = 0; k < AES_STATE_BYTES; k++) begin
            result[byte_pos(4'(k))] = st_q[byte_pos(shift_rows_src(4'(k)))];
        end
`endif
    end

    // Only a completed state is ever visible on the output bus.
    assign out_state = out_valid ? result : '0;

endmodule

// File: doc/sub_bytes_stage.md
SUB_BYTES_STAGE -- requirements
Module: sub_bytes_stage

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 4: number of S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_state is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage can accept a state.
REQ-006 SHALL have port in_state, input, 128 bits: AddRoundKey output; byte k = in_state[127-8k -: 8], FIPS-197 column-major, row = k%4, col = k/4.
REQ-007 SHALL have port out_valid, output, 1 bit: out_state is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts out_state.
REQ-009 SHALL have port out_state, output, 128 bits: substituted (and optionally shifted) state, same byte order as in_state.

Function
REQ-010 SHALL run an FSM with states IDLE, BUSY and DONE.
REQ-011 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; in_state is captured into an internal 128-bit register and the FSM goes to BUSY.
REQ-012 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; it SHALL be 0 in BUSY.
REQ-013 In BUSY, an index counter (0..16/BYTES_PER_CYCLE-1) SHALL select BYTES_PER_CYCLE consecutive bytes, starting at byte 0, substitute them combinationally and write them back in place.
REQ-014 The counter SHALL return to 0 after its last value, and the FSM SHALL then go to DONE.
REQ-015 Latency from accept to out_valid=1 SHALL be 16/BYTES_PER_CYCLE+1 cycles (5 at the default).
REQ-016 In DONE, out_valid SHALL be 1 and out_state SHALL be held stable until out_ready=1.
REQ-017 On out_ready=1 in DONE:
- with in_valid=1: capture the new state and go to BUSY (no idle bubble).
- otherwise: go to IDLE.
REQ-018 out_valid SHALL be 0 in IDLE and BUSY; in_state is ignored whenever in_ready=0.

Reset
REQ-019 rst_n=0 SHALL, asynchronously: force IDLE, clear the counter, clear the state register to 0, and drive in_ready=1 (after release), out_valid=0, out_state=0.
REQ-020 Reset asserted during BUSY or DONE SHALL discard the in-flight state; no partial result may appear on out_state.

Configuration
REQ-021 SHALL honour macro SUB_BYTES_SHIFT_ROWS_EN.
- Defined: out_state applies ShiftRows to the substituted state; output byte (r,c) = substituted byte (r,(c+r)%4).
- Undefined: out_state is the plain SubBytes result.
- Latency and handshake SHALL be identical in both builds.

Structure
REQ-022 Shared package aes_pkg SHALL hold: the 128-bit state typedef, an 8-bit byte typedef, the AES_STATE_BYTES=16 constant, and a byte-index/ShiftRows mapping function.
REQ-023 SHALL instantiate BYTES_PER_CYCLE copies of the existing combinational S_box byte-substitution module as its only sub-module; the table SHALL NOT be duplicated inline.

Verification
REQ-024 The bench SHALL cover:
- in_state all 0x00, build without macro -> out_state all 0x63, out_valid rises exactly 5 cycles after accept.
- in_state 193de3bea0f4e22b9ac68d2ae9f84808, build without macro -> d42711aee0bf98f1b8b45de51e415230.
- Same input, SUB_BYTES_SHIFT_ROWS_EN defined -> d4bf5d30e0b452aeb84111f11e2798e5.
- out_ready held 0 for 10 cycles in DONE -> out_state stable, in_ready=0; then out_ready=1 with in_valid=1 -> next state accepted the same cycle, its result arrives 5 cycles later.
- rst_n pulsed low mid-BUSY -> out_valid=0 and out_state=0 immediately; a fresh all-0xFF input then yields all 0x16.
- BYTES_PER_CYCLE=1 and =16 -> latency 17 and 2 cycles; results match the default build.
